// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle for pipe_stage_reg: upstream entry, stall/flush control,
// last-stage output, occupancy and performance counters.
interface pipe_stage_reg_if #(
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned DEPTH     = 1,
    parameter int unsigned CNT_W     = 16
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic                 in_valid;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 stall;
    logic                 flush;
    logic                 out_valid;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [OCC_W-1:0]     occupancy;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     kill_cnt;

    modport master (
        output in_valid, in_payload, stall, flush,
        input  out_valid, out_payload, occupancy, stall_cnt, kill_cnt
    );

    modport slave (
        input  in_valid, in_payload, stall, flush,
        output out_valid, out_payload, occupancy, stall_cnt, kill_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register chain with global stall and zeroing flush.
// Define PIPE_STAGE_REG_PERF_CNT_EN to build the stall_cnt/kill_cnt counters.
module pipe_stage_reg #(
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned DEPTH     = 1,
    parameter int unsigned CNT_W     = 16
) (
    input logic             clock,
    input logic             reset,
    pipe_stage_reg_if.slave pipe
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]     v_q, v_d;
    logic [PAYLOAD_W-1:0] p_q [DEPTH];
    logic [PAYLOAD_W-1:0] p_d [DEPTH];
    logic [OCC_W-1:0]     occ;

    // Flush and a bubble input both force a zero payload, keeping v=0 => p=0 everywhere.
    always_comb begin
        v_d = v_q;
        for (int k = 0; k < DEPTH; k++) begin
            p_d[k] = p_q[k];
        end
        if (pipe.flush) begin
            v_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                p_d[k] = '0;
            end
        end else if (!pipe.stall) begin
            v_d[0] = pipe.in_valid;
            p_d[0] = pipe.in_valid ? pipe.in_payload : '0;
            for (int k = 1; k < DEPTH; k++) begin
                v_d[k] = v_q[k-1];
                p_d[k] = p_q[k-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                p_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < DEPTH; k++) begin
                p_q[k] <= p_d[k];
            end
        end
    end

    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ = occ + OCC_W'(v_q[k]);
        end
    end

    assign pipe.out_valid   = v_q[DEPTH-1];
    assign pipe.out_payload = p_q[DEPTH-1];
    assign pipe.occupancy   = occ;

`ifdef PIPE_STAGE_REG_PERF_CNT_EN
    localparam int unsigned SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;
    logic [SUM_W-1:0] kill_sum;

    // kill_cnt counts only entries already held; the same-cycle input is not in occ.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        kill_sum    = SUM_W'(kill_cnt_q) + SUM_W'(occ);
        if (pipe.flush) begin
            kill_cnt_d = (kill_sum > CNT_MAX) ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
        end else if (pipe.stall && (occ != '0) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign pipe.stall_cnt = stall_cnt_q;
    assign pipe.kill_cnt  = kill_cnt_q;
`else
    assign pipe.stall_cnt = '0;
    assign pipe.kill_cnt  = '0;
`endif
endmodule
